// File: rtl/washer_pkg.sv
// washer_pkg: program codes, panel state encoding and program-advance helper
package washer_pkg;
  typedef logic [2:0] prog_t;
  localparam prog_t PROG_NONE        = 3'b000;
  localparam prog_t PROG_COLD_WASH   = 3'b001;
  localparam prog_t PROG_HOT_WASH    = 3'b010;
  localparam prog_t PROG_RINSING_DRY = 3'b011;
  localparam prog_t PROG_ONLY_DRY    = 3'b100;
  typedef enum logic [1:0] {ST_OFF, ST_SELECT, ST_RUN, ST_DONE} panel_state_t;
  function automatic prog_t next_prog(input prog_t p);
    return (p >= PROG_ONLY_DRY || p == PROG_NONE) ? PROG_COLD_WASH : p + 3'd1;
  endfunction
endpackage

// File: rtl/washer_panel_if.sv
// washer_panel_if: command/status link between the front panel and FSMW
interface washer_panel_if;
  import washer_pkg::*;
  prog_t program_selection;
  logic  start;
  logic  doorclosed;
  logic  soap;
  logic  program_done;
  logic  soap_warning;
  modport master (output program_selection, start, doorclosed, soap, input program_done, soap_warning);
  modport slave  (input program_selection, start, doorclosed, soap, output program_done, soap_warning);
endinterface

// File: rtl/washer_debounce.sv
// washer_debounce: 2-flop synchroniser, counter debounce and rising-edge pulse
module washer_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          flip;
  assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // level flips only after a full run of differing samples; any match restarts the run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync[1] : level;
      rise  <= flip && sync[1];
    end
  end
endmodule

// File: rtl/washer_panel.sv
// washer_panel: front-panel sequencer turning raw switches into clean FSMW commands
module washer_panel
  import washer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int DONE_HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power,
  input  logic                  btn_program,
  input  logic                  btn_start,
  input  logic                  btn_cancel,
  input  logic                  door_sw,
  input  logic                  soap_sw,
  washer_panel_if.master        fsm,
  output logic                  led_running,
  output logic                  led_done,
  output logic                  led_soap_warn,
  output logic                  led_door_warn
);
  localparam int HW = $clog2(DONE_HOLD_CYCLES + 1);
  logic [5:0] raw, lvl, rise;
  panel_state_t state, state_n;
  prog_t sel, sel_n;
  logic warn, warn_n, soap_q, on;
  logic [HW-1:0] hold, hold_n;
  logic unused_rise;
  assign raw = {soap_sw, door_sw, btn_cancel, btn_start, btn_program, power};
  for (genvar i = 0; i < 6; i++) begin : g_db
    washer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(raw[i]), .level(lvl[i]), .rise(rise[i])
    );
  end
  assign unused_rise = rise[0] ^ rise[5];
  // state, selection, door-warning flag, DONE hold counter and soap-warning copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_OFF;
      sel    <= PROG_NONE;
      warn   <= 1'b0;
      hold   <= '0;
      soap_q <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      warn   <= warn_n;
      hold   <= hold_n;
      soap_q <= fsm.soap_warning;
    end
  end
  // next state: power loss overrides everything; start beats program in SELECT, done beats cancel in RUN
  always_comb begin
    state_n = state;
    sel_n   = sel;
    warn_n  = rise[4] ? 1'b0 : warn;
    hold_n  = '0;
    if (!lvl[0]) begin
      state_n = ST_OFF;
      sel_n   = PROG_NONE;
      warn_n  = 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state_n = ST_SELECT;
          sel_n   = PROG_COLD_WASH;
        end
        ST_SELECT: begin
          state_n = (rise[2] && lvl[4]) ? ST_RUN : ST_SELECT;
          warn_n  = rise[2] ? !lvl[4] : warn_n;
          sel_n   = (rise[1] && !rise[2]) ? next_prog(sel) : sel;
        end
        ST_RUN: begin
          state_n = fsm.program_done ? ST_DONE : rise[3] ? ST_SELECT : ST_RUN;
          warn_n  = !lvl[4] ? 1'b1 : warn_n;
        end
        ST_DONE: begin
          hold_n  = hold + 1'b1;
          state_n = (|rise[3:1] || hold == HW'(DONE_HOLD_CYCLES - 1)) ? ST_SELECT : ST_DONE;
        end
      endcase
    end
  end
  assign on                    = state != ST_OFF;
  assign fsm.program_selection = sel;
  assign fsm.start             = state == ST_RUN;
  assign fsm.doorclosed        = on && lvl[4];
  assign fsm.soap              = on && lvl[5];
  assign led_running           = state == ST_RUN;
  assign led_done              = state == ST_DONE;
  assign led_soap_warn         = on && soap_q;
  assign led_door_warn         = on && warn && !lvl[4];
endmodule

// File: tb/tb_washer_panel.sv
// tb_washer_panel: directed sequence covering power-up, selection, run, done, cancel and power loss
module tb_washer_panel;
  logic clk = 1'b0;
  logic rst, power, door_sw, soap_sw;
  logic [2:0] btn;
  logic led_running, led_done, led_soap_warn, led_door_warn;
  int n_chk = 0;
  int n_fail = 0;
  washer_panel_if bus();
  washer_panel dut (
    .clk(clk), .rst(rst), .power(power),
    .btn_program(btn[0]), .btn_start(btn[1]), .btn_cancel(btn[2]),
    .door_sw(door_sw), .soap_sw(soap_sw), .fsm(bus),
    .led_running(led_running), .led_done(led_done),
    .led_soap_warn(led_soap_warn), .led_door_warn(led_door_warn)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input int i);
    btn[i] = 1'b1;
    tick(8);
    btn[i] = 1'b0;
    tick(8);
  endtask
  initial begin
    rst = 1'b0; power = 1'b0; door_sw = 1'b0; soap_sw = 1'b0; btn = '0;
    bus.program_done = 1'b0; bus.soap_warning = 1'b0;
    tick(3);
    chk("rst_sel", bus.program_selection, 8'h0);
    chk("rst_start", bus.start, 8'h0);
    chk("rst_leds", {led_running, led_done, led_soap_warn, led_door_warn}, 8'h0);
    rst = 1'b1;
    tick(2);
    power = 1'b1;
    tick(6);
    chk("pwr_still_off", bus.program_selection, 8'h0);
    tick(1);
    chk("pwr_select", bus.program_selection, 8'h1);
    chk("pwr_outs", {bus.start, bus.doorclosed, bus.soap, led_running, led_done, led_door_warn}, 8'h0);
    soap_sw = 1'b1;
    tick(5);
    chk("soap_early", bus.soap, 8'h0);
    tick(1);
    chk("soap_on", bus.soap, 8'h1);
    bus.soap_warning = 1'b1;
    tick(1);
    chk("soap_warn_on", led_soap_warn, 8'h1);
    bus.soap_warning = 1'b0;
    tick(1);
    chk("soap_warn_off", led_soap_warn, 8'h0);
    press(0);
    chk("prog_1", bus.program_selection, 8'h2);
    press(0);
    chk("prog_2", bus.program_selection, 8'h3);
    btn[0] = 1'b1; tick(1); btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1; tick(8); btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(8);
    chk("prog_3_bounce", bus.program_selection, 8'h4);
    press(0);
    chk("prog_4_wrap", bus.program_selection, 8'h1);
    press(0);
    chk("prog_5", bus.program_selection, 8'h2);
    press(1);
    chk("door_open_start", bus.start, 8'h0);
    chk("door_warn_set", led_door_warn, 8'h1);
    door_sw = 1'b1;
    tick(5);
    chk("door_warn_hold", led_door_warn, 8'h1);
    tick(1);
    chk("door_warn_clr", led_door_warn, 8'h0);
    chk("doorclosed", bus.doorclosed, 8'h1);
    btn[1] = 1'b1;
    tick(6);
    chk("start_early", bus.start, 8'h0);
    tick(1);
    chk("start_on", {bus.start, led_running}, 8'h3);
    btn[1] = 1'b0;
    tick(8);
    press(0);
    chk("run_sel_frozen", bus.program_selection, 8'h2);
    chk("run_still", bus.start, 8'h1);
    bus.program_done = 1'b1;
    tick(1);
    bus.program_done = 1'b0;
    chk("done_enter", {bus.start, led_running, led_done}, 8'h1);
    tick(15);
    chk("done_hold", led_done, 8'h1);
    tick(1);
    chk("done_exit", led_done, 8'h0);
    chk("done_sel_kept", bus.program_selection, 8'h2);
    press(1);
    chk("restart", bus.start, 8'h1);
    btn[2] = 1'b1;
    tick(6);
    chk("cancel_early", bus.start, 8'h1);
    tick(1);
    chk("cancel_stop", {bus.start, led_running, led_done}, 8'h0);
    chk("cancel_sel_kept", bus.program_selection, 8'h2);
    btn[2] = 1'b0;
    tick(8);
    press(1);
    chk("restart2", bus.start, 8'h1);
    btn[2] = 1'b1;
    tick(6);
    bus.program_done = 1'b1;
    tick(1);
    bus.program_done = 1'b0;
    chk("done_beats_cancel", {bus.start, led_done}, 8'h1);
    btn[2] = 1'b0;
    btn[0] = 1'b1;
    tick(6);
    chk("done_btn_wait", led_done, 8'h1);
    tick(1);
    chk("done_btn_exit", led_done, 8'h0);
    btn[0] = 1'b0;
    tick(8);
    chk("done_btn_consumed", bus.program_selection, 8'h2);
    press(1);
    chk("restart3", bus.start, 8'h1);
    power = 1'b0;
    tick(5);
    chk("pwr_loss_early", bus.start, 8'h1);
    tick(2);
    chk("pwr_loss_off", {bus.program_selection, bus.start, bus.doorclosed, bus.soap}, 8'h0);
    chk("pwr_loss_leds", {led_running, led_done, led_soap_warn, led_door_warn}, 8'h0);
    power = 1'b1;
    tick(7);
    chk("repower_sel", bus.program_selection, 8'h1);
    press(1);
    chk("restart4", bus.start, 8'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {bus.program_selection, bus.start, led_running}, 8'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
